// File: rtl/mdr_handshake_if.sv
// Handshake bundle for the memory data register: CPU-side controls, status
// flags and the memory request/acknowledge port.
interface mdr_handshake_if #(
    parameter int DATA_W = 16
);
    logic              bus_load;
    logic              bus_drive;
    logic              start_rd;
    logic              start_wr;
    logic              byte_mode;
    logic              sign_ext;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              busy;
    logic              done;
    logic              timeout_err;

    // The MDR itself.
    modport slave (
        input  bus_load, bus_drive, start_rd, start_wr, byte_mode, sign_ext,
        input  mem_rdata, mem_ack,
        output mem_req, mem_we, mem_wdata, busy, done, timeout_err
    );

    // The CPU control unit plus memory that surround the MDR.
    modport master (
        output bus_load, bus_drive, start_rd, start_wr, byte_mode, sign_ext,
        output mem_rdata, mem_ack,
        input  mem_req, mem_we, mem_wdata, busy, done, timeout_err
    );
endinterface

// File: rtl/mdr_handshake.sv
// Memory data register between the CPU tristate bus and a stallable memory
// port: req/ack FSM, byte mode with optional sign extension, access timeout.
module mdr_handshake #(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    inout  wire  [DATA_W-1:0] bus_data,
    mdr_handshake_if.slave    ifc
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_byte;
    logic              r_sext;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_busy;
    logic              r_done;
    logic              r_timeout_err;

    logic              w_start;
    logic [DATA_W-1:0] w_wr_word;
    logic [DATA_W-1:0] w_rd_word;
    logic [DATA_W-1:0] w_rd_byte;

    assign w_start   = ifc.start_rd | ifc.start_wr;
    assign w_wr_word = ifc.byte_mode ? DATA_W'(r_data[7:0]) : r_data;
    assign w_rd_byte = r_sext ? DATA_W'($signed(ifc.mem_rdata[7:0]))
                              : DATA_W'(ifc.mem_rdata[7:0]);
    assign w_rd_word = r_byte ? w_rd_byte : ifc.mem_rdata;

    // Bus is released while reset is held, whatever bus_drive says.
    assign bus_data = (ifc.bus_drive && !reset) ? r_data : {DATA_W{1'bz}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_data        <= '0;
            r_cnt         <= '0;
            r_byte        <= 1'b0;
            r_sext        <= 1'b0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_wdata   <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state       <= ifc.start_rd ? S_RD : S_WR;
                        r_byte        <= ifc.byte_mode;
                        r_sext        <= ifc.sign_ext;
                        r_cnt         <= '0;
                        r_timeout_err <= 1'b0;
                        r_mem_req     <= 1'b1;
                        r_mem_we      <= ~ifc.start_rd;
                        r_mem_wdata   <= w_wr_word;
                        r_busy        <= 1'b1;
                    end else if (ifc.bus_load && !ifc.bus_drive) begin
                        r_data <= bus_data;
                    end
                end
                S_RD, S_WR: begin
                    // An ack in the timeout cycle still counts as success.
                    if (ifc.mem_ack) begin
                        r_state   <= S_FIN;
                        r_mem_req <= 1'b0;
                        if (r_state == S_RD)
                            r_data <= w_rd_word;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_state       <= S_FIN;
                        r_mem_req     <= 1'b0;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FIN: begin
                    // First FIN cycle raises done; the second returns to idle.
                    if (!r_done) begin
                        r_done <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_mem_req <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign ifc.mem_req     = r_mem_req;
    assign ifc.mem_we      = r_mem_we;
    assign ifc.mem_wdata   = r_mem_wdata;
    assign ifc.busy        = r_busy;
    assign ifc.done        = r_done;
    assign ifc.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mdr_handshake.sv
// Directed bench for mdr_handshake: bus load/drive, word and byte reads,
// byte write, timeout, start collisions and mid-access reset.
module tb_mdr_handshake;
    localparam int DATA_W = 16;

    logic              clk;
    logic              reset;
    wire  [DATA_W-1:0] bus_data;
    logic [DATA_W-1:0] tb_bus_val;
    logic              tb_bus_en;
    int                checks;
    int                failures;
    int                req_cycles;

    mdr_handshake_if #(.DATA_W(DATA_W)) ifc ();

    mdr_handshake #(.DATA_W(DATA_W), .TIMEOUT(15), .CNT_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus_data (bus_data),
        .ifc      (ifc)
    );

    assign bus_data = tb_bus_en ? tb_bus_val : {DATA_W{1'bz}};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reads the data register through the bus within the current cycle.
    task automatic check_data(input string tag, input logic [DATA_W-1:0] exp);
        ifc.bus_drive = 1'b1;
        #1;
        check(tag, 32'(bus_data), 32'(exp));
        ifc.bus_drive = 1'b0;
        #1;
    endtask

    task automatic load_bus(input logic [DATA_W-1:0] val);
        tb_bus_en     = 1'b1;
        tb_bus_val    = val;
        ifc.bus_load  = 1'b1;
        tick();
        ifc.bus_load  = 1'b0;
        tb_bus_en     = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; tb_bus_en = 1'b0; tb_bus_val = '0;
        ifc.bus_load = 0; ifc.bus_drive = 0; ifc.start_rd = 0; ifc.start_wr = 0;
        ifc.byte_mode = 0; ifc.sign_ext = 0; ifc.mem_rdata = '0; ifc.mem_ack = 0;
        tick(); tick();
        check("rst_req", 32'(ifc.mem_req), 0);
        check("rst_busy_done_err", {29'd0, ifc.busy, ifc.done, ifc.timeout_err}, 0);
        check("rst_wdata", 32'(ifc.mem_wdata), 0);
        reset = 1'b0;
        tick();
        check_data("rst_data", 16'h0000);

        // Load and drive
        load_bus(16'hA5C3);
        check_data("load_drive", 16'hA5C3);
        tb_bus_en = 1'b1; tb_bus_val = 16'h5A5A; #1;
        check("bus_released", 32'(bus_data), 32'h5A5A);
        tb_bus_en = 1'b0;

        // Word read, ack in the 4th request cycle
        ifc.start_rd = 1'b1;
        tick();
        ifc.start_rd = 1'b0;
        check("wr_rd_req_we", {30'd0, ifc.mem_req, ifc.mem_we}, 32'b10);
        check("wr_rd_busy", 32'(ifc.busy), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wr_rd_req_hold", {30'd0, ifc.mem_req, ifc.done}, 32'b10);
        end
        ifc.mem_ack = 1'b1; ifc.mem_rdata = 16'h1234;
        tick();
        ifc.mem_ack = 1'b0; ifc.mem_rdata = 16'h0000;
        check("wr_rd_req_drop", {30'd0, ifc.mem_req, ifc.done}, 32'b00);
        tick();
        check("wr_rd_done", {29'd0, ifc.done, ifc.busy, ifc.timeout_err}, 32'b110);
        check_data("wr_rd_data", 16'h1234);
        tick();
        check("wr_rd_idle", {30'd0, ifc.done, ifc.busy}, 32'b00);

        // Byte read, sign-extended
        ifc.byte_mode = 1'b1; ifc.sign_ext = 1'b1; ifc.start_rd = 1'b1;
        tick();
        ifc.start_rd = 1'b0; ifc.byte_mode = 1'b0; ifc.sign_ext = 1'b0;
        ifc.mem_ack = 1'b1; ifc.mem_rdata = 16'h7F80;
        tick();
        ifc.mem_ack = 1'b0;
        tick(); tick();
        check_data("byte_rd_sext", 16'hFF80);

        // Byte read, zero-extended; sign_ext raised after start must not matter
        ifc.byte_mode = 1'b1; ifc.sign_ext = 1'b0; ifc.start_rd = 1'b1;
        tick();
        ifc.start_rd = 1'b0; ifc.byte_mode = 1'b0; ifc.sign_ext = 1'b1;
        ifc.mem_ack = 1'b1; ifc.mem_rdata = 16'h7F80;
        tick();
        ifc.mem_ack = 1'b0; ifc.sign_ext = 1'b0;
        tick(); tick();
        check_data("byte_rd_zext", 16'h0080);

        // Byte write, zero-wait
        load_bus(16'hBEEF);
        ifc.byte_mode = 1'b1; ifc.start_wr = 1'b1;
        tick();
        ifc.start_wr = 1'b0; ifc.byte_mode = 1'b0;
        check("bw_req_we", {30'd0, ifc.mem_req, ifc.mem_we}, 32'b11);
        check("bw_wdata", 32'(ifc.mem_wdata), 32'h00EF);
        ifc.mem_ack = 1'b1;
        tick();
        ifc.mem_ack = 1'b0;
        check("bw_fin", {30'd0, ifc.mem_req, ifc.done}, 32'b00);
        tick();
        check("bw_done", 32'(ifc.done), 1);
        check_data("bw_data_kept", 16'hBEEF);
        tick();
        check("bw_idle", 32'(ifc.busy), 0);

        // Timeout on read
        ifc.start_rd = 1'b1;
        tick();
        ifc.start_rd = 1'b0;
        req_cycles = 0;
        for (int i = 0; i < 40 && ifc.mem_req; i++) begin
            req_cycles++;
            tick();
        end
        check("to_req_cycles", 32'(req_cycles), 15);
        check("to_fin_no_done", 32'(ifc.done), 0);
        tick();
        check("to_done_err", {30'd0, ifc.done, ifc.timeout_err}, 32'b11);
        tick();
        check("to_err_sticky", {30'd0, ifc.busy, ifc.timeout_err}, 32'b01);
        check_data("to_data_kept", 16'hBEEF);

        // Next start clears the error
        ifc.start_wr = 1'b1;
        tick();
        ifc.start_wr = 1'b0;
        check("to_err_clear", {30'd0, ifc.timeout_err, ifc.mem_we}, 32'b01);
        check("wr_word_wdata", 32'(ifc.mem_wdata), 32'hBEEF);
        ifc.mem_ack = 1'b1;
        tick();
        ifc.mem_ack = 1'b0;
        tick(); tick();

        // Ack coincident with the timeout cycle completes normally
        ifc.start_rd = 1'b1;
        tick();
        ifc.start_rd = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        check("race_req_still", 32'(ifc.mem_req), 1);
        ifc.mem_ack = 1'b1; ifc.mem_rdata = 16'h4321;
        tick();
        ifc.mem_ack = 1'b0;
        tick();
        check("race_done_noerr", {30'd0, ifc.done, ifc.timeout_err}, 32'b10);
        check_data("race_data", 16'h4321);
        tick();

        // Ack while idle is ignored
        ifc.mem_ack = 1'b1; ifc.mem_rdata = 16'h9999;
        tick();
        ifc.mem_ack = 1'b0;
        check("idle_ack_busy_done", {30'd0, ifc.busy, ifc.done}, 32'b00);
        check_data("idle_ack_data", 16'h4321);

        // Simultaneous starts: read wins; bus_load and start_wr during RD ignored
        ifc.start_rd = 1'b1; ifc.start_wr = 1'b1;
        tick();
        ifc.start_rd = 1'b0; ifc.start_wr = 1'b0;
        check("coll_read_wins", {30'd0, ifc.mem_req, ifc.mem_we}, 32'b10);
        check_data("mid_access_drive", 16'h4321);
        tb_bus_en = 1'b1; tb_bus_val = 16'hDEAD; ifc.bus_load = 1'b1; ifc.start_wr = 1'b1;
        tick();
        tb_bus_en = 1'b0; ifc.bus_load = 1'b0; ifc.start_wr = 1'b0;
        ifc.mem_ack = 1'b1; ifc.mem_rdata = 16'h0F0F;
        tick();
        ifc.mem_ack = 1'b0;
        tick(); tick();
        check_data("coll_load_ignored", 16'h0F0F);
        tick();
        check("coll_wr_not_queued", {30'd0, ifc.busy, ifc.mem_req}, 32'b00);

        // Reset in the middle of a write
        ifc.start_wr = 1'b1;
        tick();
        ifc.start_wr = 1'b0;
        check("rstwr_req", 32'(ifc.mem_req), 1);
        tick();
        reset = 1'b1;
        #1;
        check("rstwr_req_drop", {29'd0, ifc.mem_req, ifc.busy, ifc.done}, 32'b000);
        tick();
        reset = 1'b0;
        tick();
        check("rstwr_no_done1", {30'd0, ifc.done, ifc.busy}, 32'b00);
        tick();
        check("rstwr_no_done2", {30'd0, ifc.done, ifc.busy}, 32'b00);
        check_data("rstwr_data_zero", 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
